// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_phase_scheduler
//  Purpose  : Demand-driven phase scheduler for one junction (main through
//             lanes M1/M2, main turn lane MT, side road S) with emergency
//             preemption. Timing advances on an external 1 Hz tick.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_phase_scheduler #(
    parameter int T_MAIN_MIN = 7,
    parameter int T_TURN     = 5,
    parameter int T_SIDE     = 3,
    parameter int T_YEL      = 2,
    parameter int T_ALLRED   = 1,
    parameter int CW         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       req_side,
    input  logic       req_turn,
    input  logic       req_emg,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic [3:0] phase,
    output logic       emg_ack
);

    typedef enum logic [3:0] {
        MAIN_G = 4'd0,
        M2_Y   = 4'd1,
        TURN_G = 4'd2,
        TURN_Y = 4'd3,
        MAIN_Y = 4'd4,
        ALL_R  = 4'd5,
        SIDE_G = 4'd6,
        SIDE_Y = 4'd7,
        EMG    = 4'd8
    } state_t;

    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

    // Last count value of each timed state (exit happens when a tick sees it)
    localparam logic [CW-1:0] MAIN_LAST   = CW'(T_MAIN_MIN - 1);
    localparam logic [CW-1:0] TURN_LAST   = CW'(T_TURN - 1);
    localparam logic [CW-1:0] SIDE_LAST   = CW'(T_SIDE - 1);
    localparam logic [CW-1:0] YEL_LAST    = CW'(T_YEL - 1);
    localparam logic [CW-1:0] ALLRED_LAST = CW'(T_ALLRED - 1);

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   next_count;
    logic            pend_side;
    logic            pend_turn;
    logic            from_side;
    logic            next_pend_side;
    logic            next_pend_turn;
    logic            next_from_side;
    logic [2:0]      next_m1;
    logic [2:0]      next_m2;
    logic [2:0]      next_mt;
    logic [2:0]      next_s;

    assign phase = state;

    // State, counter, demand latches and registered lamp outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MAIN_G;
            count     <= '0;
            pend_side <= 1'b0;
            pend_turn <= 1'b0;
            from_side <= 1'b0;
            emg_ack   <= 1'b0;
            light_M1  <= LAMP_G;
            light_M2  <= LAMP_G;
            light_MT  <= LAMP_R;
            light_S   <= LAMP_R;
        end else begin
            state     <= next_state;
            count     <= next_count;
            pend_side <= next_pend_side;
            pend_turn <= next_pend_turn;
            from_side <= next_from_side;
            emg_ack   <= (next_state == EMG);
            light_M1  <= next_m1;
            light_M2  <= next_m2;
            light_MT  <= next_mt;
            light_S   <= next_s;
        end
    end

    // Next-state selection; transitions always use the pre-transition count
    always_comb begin
        next_state     = state;
        next_from_side = from_side;
        case (state)
            MAIN_G: begin
                if (req_emg)
                    next_state = MAIN_Y;
                else if (tick && count == MAIN_LAST) begin
                    if (pend_turn)      next_state = M2_Y;
                    else if (pend_side) next_state = MAIN_Y;
                end
            end
            M2_Y: begin
                if (tick && count == YEL_LAST)
                    next_state = req_emg ? MAIN_Y : TURN_G;
            end
            TURN_G: begin
                if (req_emg || (tick && count == TURN_LAST))
                    next_state = TURN_Y;
            end
            TURN_Y, MAIN_Y: begin
                if (tick && count == YEL_LAST)
                    next_state = ALL_R;
            end
            SIDE_G: begin
                if (req_emg || (tick && count == SIDE_LAST))
                    next_state = SIDE_Y;
            end
            SIDE_Y: begin
                if (tick && count == YEL_LAST) begin
                    next_state     = ALL_R;
                    next_from_side = 1'b1;
                end
            end
            ALL_R: begin
                if (tick && count == ALLRED_LAST) begin
                    next_from_side = 1'b0;
                    if (req_emg)        next_state = EMG;
                    else if (from_side) next_state = MAIN_G;
                    else if (pend_side) next_state = SIDE_G;
                    else                next_state = MAIN_G;
                end
            end
            EMG: begin
                if (!req_emg)
                    next_state = MAIN_G;
            end
            default: next_state = MAIN_G;
        endcase
    end

    // Counter: clears on entry, advances on ticks; MAIN_G and EMG saturate
    always_comb begin
        next_count = count;
        if (next_state != state)
            next_count = '0;
        else if (tick) begin
            if (state == MAIN_G) begin
                if (count != MAIN_LAST) next_count = count + 1'b1;
            end else if (state != EMG) begin
                next_count = count + 1'b1;
            end
        end
    end

    // Demand latches: set outside the served phase, cleared on its entry
    always_comb begin
        next_pend_side = pend_side | (req_side && state != SIDE_G);
        next_pend_turn = pend_turn | (req_turn && state != TURN_G);
        if (next_state == SIDE_G && state != SIDE_G) next_pend_side = 1'b0;
        if (next_state == TURN_G && state != TURN_G) next_pend_turn = 1'b0;
    end

    // Lamp decode of the upcoming state, registered alongside phase
    always_comb begin
        next_m1 = LAMP_R;
        next_m2 = LAMP_R;
        next_mt = LAMP_R;
        next_s  = LAMP_R;
        case (next_state)
            MAIN_G: begin next_m1 = LAMP_G; next_m2 = LAMP_G; end
            M2_Y:   begin next_m1 = LAMP_G; next_m2 = LAMP_Y; end
            TURN_G: begin next_m1 = LAMP_G; next_mt = LAMP_G; end
            TURN_Y: begin next_m1 = LAMP_Y; next_mt = LAMP_Y; end
            MAIN_Y: begin next_m1 = LAMP_Y; next_m2 = LAMP_Y; end
            SIDE_G: next_s = LAMP_G;
            SIDE_Y: next_s = LAMP_Y;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Demand-driven phase scheduler for one junction: main road through lanes (M1, M2), main-road turn lane (MT) and side road (S).
- Main road rests in green. Latched side-road and turn-lane requests are served only after a minimum main green.
- Emergency requests preempt through the yellow and all-red phases into an all-red hold.
- Timing advances on an external 1 Hz tick, so the block sits downstream of the shared seconds prescaler.

Parameters:
T_MAIN_MIN, 7, minimum main green in ticks
T_TURN, 5, turn-lane green in ticks
T_SIDE, 3, side-road green in ticks
T_YEL, 2, every yellow phase in ticks
T_ALLRED, 1, all-red clearance in ticks
CW, 4, phase counter width; every T_* must be >=1 and <2^CW

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tick  in  1  one-clk pulse per second
req_side  in  1  side-road sensor pulse or level
req_turn  in  1  turn-lane sensor pulse or level
req_emg  in  1  emergency preemption, level
light_M1  out  3  lamp code: 001 green, 010 yellow, 100 red
light_M2  out  3  lamp code, same encoding
light_MT  out  3  lamp code, same encoding
light_S  out  3  lamp code, same encoding
phase  out  4  current state encoding
emg_ack  out  1  high while in EMG

Behaviour:
- States and encodings, with lamps listed as M1/M2/MT/S:
  - MAIN_G=0: G/G/R/R
  - M2_Y=1: G/Y/R/R
  - TURN_G=2: G/R/G/R
  - TURN_Y=3: Y/R/Y/R
  - MAIN_Y=4: Y/Y/R/R
  - ALL_R=5: R/R/R/R
  - SIDE_G=6: R/R/R/G
  - SIDE_Y=7: R/R/R/Y
  - EMG=8: R/R/R/R
- Outputs are registered and change in the same cycle as phase. There are no combinational glitches and no illegal codes.
- Reset, checked every clk while rst=1, takes priority over everything:
  - phase=MAIN_G, count=0, pend_side=pend_turn=0, from_side=0, emg_ack=0.
  - lights 001/001/100/100.
- Counter:
  - count clears to 0 on every state entry and advances only on clks with tick=1.
  - A timed state of duration T exits on the clk whose tick sees count==T-1.
- Demand latches:
  - pend_side is set by req_side when phase!=SIDE_G and cleared on entry to SIDE_G.
  - pend_turn is set by req_turn when phase!=TURN_G and cleared on entry to TURN_G.
  - When set and clear coincide, clear wins.
  - Both latches survive preemption.
- MAIN_G:
  - count saturates at T_MAIN_MIN-1.
  - When req_emg=1, goes to MAIN_Y on the next clk, regardless of count or tick.
  - Otherwise, on a tick with count==T_MAIN_MIN-1: pend_turn goes to M2_Y (turn has priority), else pend_side goes to MAIN_Y, else hold.
  - With no demand it holds indefinitely.
- M2_Y: lasts T_YEL. Goes to MAIN_Y if req_emg=1 at exit, else to TURN_G.
- TURN_G: lasts T_TURN, then TURN_Y. req_emg=1 aborts to TURN_Y on the next clk.
- TURN_Y and MAIN_Y: last T_YEL, then ALL_R.
- SIDE_G: lasts T_SIDE, then SIDE_Y. req_emg=1 aborts to SIDE_Y on the next clk.
- SIDE_Y: lasts T_YEL, then ALL_R, with from_side set to 1.
- Yellow states are never shortened by req_emg.
- ALL_R: lasts T_ALLRED. Exit priority:
  - req_emg goes to EMG;
  - else from_side goes to MAIN_G;
  - else pend_side goes to SIDE_G;
  - else MAIN_G.
  - from_side clears on ALL_R exit.
- EMG:
  - Holds while req_emg=1; emg_ack=1 only here.
  - Goes to MAIN_G on the first clk with req_emg=0, without waiting for a tick.
- tick and a state change on the same clk: the transition uses the pre-transition count. The new state starts at count=0, and that tick is not credited to it.
- Simultaneous req_side and req_turn: both are latched; the turn phase runs first, then the side phase in the same cycle via ALL_R.

Test Plan:
- Reset, then 40 ticks, one every 4 clks, with no requests -> phase stays 0; lights 001/001/100/100; emg_ack=0.
- req_side pulse at tick 2 -> exit MAIN_G on tick 7. Sequence: MAIN_Y(2), ALL_R(1), SIDE_G(3), SIDE_Y(2), ALL_R(1), MAIN_G. light_S=001 only in SIDE_G; pend_side clears on SIDE_G entry.
- req_turn and req_side in the same clk -> M2_Y(2), TURN_G(5), TURN_Y(2), ALL_R(1), SIDE_G(3), SIDE_Y(2), ALL_R(1), MAIN_G. Both latches end at 0.
- req_emg rises in SIDE_G at count=1 -> SIDE_Y next clk; after 2 ticks ALL_R; after 1 tick EMG with emg_ack=1 and all lights 100. Dropping req_emg -> MAIN_G next clk, lights 001/001/100/100.
- req_emg rises during M2_Y with pend_turn=1 -> M2_Y completes 2 ticks, then MAIN_Y(2), ALL_R(1), EMG. pend_turn stays 1; after release, MAIN_G runs 7 ticks, then M2_Y.
- rst pulsed for 1 clk mid TURN_G, with a tick on that clk -> next clk phase=0, count=0, latches cleared, lights 001/001/100/100.
